// File: rtl/stage_2_scheduler.sv
// Range/low update stage of a range coder: one shared 16x16 multiplier sequenced
// by a small FSM, valid/ready handshakes on both sides.
module stage_2_scheduler #(
  parameter int DATA_16 = 16,
  parameter int DATA_32 = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_16-1:0] UU,
  input  logic [DATA_16-1:0] VV,
  input  logic [DATA_16-1:0] A,
  input  logic [DATA_16-1:0] in_range,
  input  logic [DATA_16-1:0] in_low,
  input  logic               COMP_mux_1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_16-1:0] range,
  output logic [DATA_16-1:0] low,
  output logic               busy,
  output logic [DATA_16-1:0] sym_count
);

  typedef enum logic [2:0] {IDLE, MUL_U, MUL_A, MUL_V, DONE} state_t;

  localparam logic [DATA_16-1:0] RANGE_RST = {1'b1, {(DATA_16-1){1'b0}}};

  state_t state, state_next;

  logic [DATA_16-1:0] uu_q, vv_q, a_q, range_in_q, low_in_q, rr_q;
  logic [DATA_16-1:0] low_w;
  logic [DATA_16-1:0] range_q, low_q, count_q;
  logic [DATA_16-1:0] mul_b;
  logic [DATA_32-1:0] product;
  logic [DATA_16-1:0] prod_lo;
  logic               unused_product_hi;

  wire take = in_valid && in_ready;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  // NOTE: the default assignment up front keeps this block purely combinational;
  // a path that left state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (take) state_next = COMP_mux_1 ? MUL_U : MUL_V;
      MUL_U:   state_next = MUL_A;
      MUL_A:   state_next = DONE;
      MUL_V:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Single time-shared multiplier; the operand is chosen by the current state.
  always_comb begin
    mul_b = '0;
    unique case (state)
      MUL_U:   mul_b = uu_q;
      MUL_A:   mul_b = a_q;
      MUL_V:   mul_b = vv_q;
      default: mul_b = '0;
    endcase
  end

  assign product           = DATA_32'(rr_q) * DATA_32'(mul_b);
  assign prod_lo           = product[DATA_16-1:0];
  // The coder arithmetic is modulo 2^16; the upper product half is discarded.
  assign unused_product_hi = ^product[DATA_32-1:DATA_16];

  // Operand capture. These are always loaded on a transfer before being read,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      uu_q       <= UU;
      vv_q       <= VV;
      a_q        <= A;
      range_in_q <= in_range;
      low_in_q   <= in_low;
      rr_q       <= in_range >> 8;
    end
    if (state == MUL_U) low_w <= low_in_q + range_in_q - prod_lo;
  end

  // Result registers change only on entry to DONE, so outputs hold the last
  // result through every other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      range_q <= RANGE_RST;
      low_q   <= '0;
      count_q <= '0;
    end else begin
      unique case (state)
        MUL_A: begin
          range_q <= prod_lo;
          low_q   <= low_w;
        end
        MUL_V: begin
          range_q <= range_in_q - prod_lo;
          low_q   <= low_in_q;
        end
        DONE:    if (out_ready) count_q <= count_q + DATA_16'(1);
        default: ;
      endcase
    end
  end

  assign range     = range_q;
  assign low       = low_q;
  assign sym_count = count_q;

endmodule

// File: tb/tb_stage_2_scheduler.sv
// Randomized self-checking bench for stage_2_scheduler against an arithmetic
// reference model of the range/low update rules.
module tb_stage_2_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] UU, VV, A, in_range, in_low;
  logic        COMP_mux_1;
  logic        out_valid, out_ready;
  logic [15:0] range, low;
  logic        busy;
  logic [15:0] sym_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = '0;

  always #5 clk = ~clk;

  stage_2_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .UU(UU), .VV(VV), .A(A), .in_range(in_range), .in_low(in_low),
    .COMP_mux_1(COMP_mux_1), .out_valid(out_valid), .out_ready(out_ready),
    .range(range), .low(low), .busy(busy), .sym_count(sym_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {range, low} after one symbol, computed with plain modular arithmetic.
  function automatic logic [31:0] model(input bit comp, input int rng, input int lo,
                                        input int uu, input int vv, input int a);
    int rr;
    int r;
    int l;
    rr = rng / 256;
    if (comp) begin
      l = (lo + rng - ((rr * uu) % 65536) + 65536) % 65536;
      r = (rr * a) % 65536;
    end else begin
      r = (rng - ((rr * vv) % 65536) + 65536) % 65536;
      l = lo;
    end
    return {r[15:0], l[15:0]};
  endfunction

  task automatic scramble();
    UU         = 16'($urandom);
    VV         = 16'($urandom);
    A          = 16'($urandom);
    in_range   = 16'($urandom);
    in_low     = 16'($urandom);
    COMP_mux_1 = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_count = '0;
  endtask

  // One symbol: transfer, measure latency, hold in DONE for 'hold' cycles, release.
  task automatic run_symbol(input bit comp, input logic [15:0] rng, input logic [15:0] lo,
                            input logic [15:0] uu, input logic [15:0] vv,
                            input logic [15:0] a, input int hold);
    logic [31:0] exp;
    int lat;
    int budget;
    @(negedge clk);
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("in_ready_idle", in_ready, 1);
    COMP_mux_1 = comp; in_range = rng; in_low = lo; UU = uu; VV = vv; A = a;
    in_valid = 1'b1;
    exp = model(comp, rng, lo, uu, vv, a);
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble();
    check("busy_after_take", {busy, in_ready}, 2'b10);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
      scramble();
    end
    check("latency", lat, comp ? 3 : 2);
    check("result", {range, low}, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 scramble();
      check("hold_stable", {out_valid, in_ready, range, low}, {1'b1, 1'b0, exp});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_count++;
    check("sym_count", sym_count, exp_count);
    check("released", {out_valid, in_ready, busy, range, low}, {3'b010, exp});
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp;
    int pulses;
    int got;
    int budget;
    logic [15:0] r16, l16, u16, v16, a16;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    UU = '0; VV = '0; A = '0; in_range = '0; in_low = '0; COMP_mux_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state", {out_valid, in_ready, busy, range, low, sym_count},
          {3'b010, 16'h8000, 16'h0000, 16'h0000});

    // Directed vectors, including wraparound and a 5-cycle backpressure hold.
    run_symbol(1'b1, 16'h8000, 16'h0000, 16'h0010, 16'h0000, 16'h0020, 0);
    check("vec_comp1", {range, low}, {16'h1000, 16'h7800});
    run_symbol(1'b0, 16'h8000, 16'h1234, 16'h0000, 16'h0040, 16'h0000, 5);
    check("vec_comp0", {range, low}, {16'h6000, 16'h1234});
    run_symbol(1'b1, 16'h2000, 16'hF000, 16'h0000, 16'h0000, 16'h0001, 1);
    check("vec_wrap", {range, low}, {16'h0020, 16'h1000});

    for (int n = 0; n < 20; n++) begin
      r16 = 16'($urandom); l16 = 16'($urandom); u16 = 16'($urandom);
      v16 = 16'($urandom); a16 = 16'($urandom);
      run_symbol(1'($urandom), r16, l16, u16, v16, a16, int'($urandom_range(0, 3)));
    end

    // Reset while in MUL_A aborts the symbol without output or count.
    do_reset();
    @(negedge clk);
    COMP_mux_1 = 1'b1; in_range = 16'h8000; in_low = 16'h0001; UU = 16'h0003; A = 16'h0004;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_mul_a", {out_valid, in_ready, busy, range, low, sym_count},
          {3'b010, 16'h8000, 16'h0000, 16'h0000});
    repeat (4) @(posedge clk);
    #1 check("abort_no_output", {out_valid, sym_count}, {1'b0, 16'h0000});

    // Reset wins over in_valid in IDLE.
    @(negedge clk);
    in_valid = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; reset = 1'b0;
    check("reset_over_valid", {in_ready, busy}, 2'b10);

    // Reset wins over out_ready in DONE.
    @(negedge clk);
    COMP_mux_1 = 1'b0; in_range = 16'h4000; in_low = 16'h0000; VV = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 check("reached_done", out_valid, 1);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; out_ready = 1'b0;
    check("reset_over_ready", {out_valid, sym_count, range}, {1'b0, 16'h0000, 16'h8000});

    // Back-to-back: in_valid and out_ready held high for four symbols.
    do_reset();
    scramble();
    in_valid = 1'b1; out_ready = 1'b1;
    pulses = 0; got = 0; budget = 0;
    while (got < 4 && budget < 60) begin
      @(negedge clk);
      budget++;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("b2b_unexpected", 1, 0);
        end else begin
          exp = q.pop_front();
          check("b2b_result", {range, low}, exp);
        end
        got++;
      end
      if (in_ready && in_valid) begin
        q.push_back(model(COMP_mux_1, in_range, in_low, UU, VV, A));
        pulses++;
      end
      @(posedge clk);
      #1;
      if (pulses >= 4) in_valid = 1'b0;
      else if (!in_ready) scramble();
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_pulses", pulses, 4);
    check("b2b_results", got, 4);
    check("b2b_sym_count", sym_count, 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
